// File: rtl/terrain_crater_sched_pkg.sv
// Shared constants, FSM state encoding and latched request record for the
// terrain crater scheduler.
package terrain_pkg;
  localparam int unsigned NCOLS = 640;
  localparam int unsigned NROWS = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHORD,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_PAUSE
  } crater_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] r;
  } crater_req_t;
endpackage

// File: rtl/terrain_crater_sched_chord.sv
// Iterative half-chord: h walks down from r until h^2 + dx^2 <= r^2.
module terrain_chord (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [5:0]         r_i,
  input  logic signed [10:0] dx_i,
  output logic [5:0]         h_o,
  output logic               done_o
);
  logic [5:0]  h_q, h_d, r_q, r_d;
  logic        active_q, active_d;
  logic [10:0] dx_abs;
  logic [11:0] h_sq, dx_sq, r_sq;
  logic [12:0] sum;
  logic        fits;

  always_comb begin
    dx_abs = dx_i[10] ? 11'(-dx_i) : 11'(dx_i);
    h_sq   = 12'(h_q) * 12'(h_q);
    dx_sq  = 12'(dx_abs) * 12'(dx_abs);
    r_sq   = 12'(r_q) * 12'(r_q);
    sum    = {1'b0, h_sq} + {1'b0, dx_sq};
    // h == 0 terminates even if dx lies outside the radius
    fits   = (sum <= {1'b0, r_sq}) || (h_q == '0);
  end

  always_comb begin
    h_d      = h_q;
    r_d      = r_q;
    active_d = active_q;
    if (start_i) begin
      h_d      = r_i;
      r_d      = r_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (fits) active_d = 1'b0;
      else      h_d      = h_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= '0;
      r_q      <= '0;
      active_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      r_q      <= r_d;
      active_q <= active_d;
    end
  end

  assign h_o    = h_q;
  assign done_o = active_q & fits;
endmodule

// File: rtl/terrain_crater_sched.sv
// Crater carving sequencer: read-modify-write of terrain columns during vblank.
// Define TERRAIN_RR_ARB_EN for round-robin arbitration (default: fixed priority).
module terrain_crater_sched
  import terrain_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_done,
  input  logic                  vblank,
  input  logic [9:0]            display_x,
  input  logic [1:0]            req,
  input  logic [1:0][9:0]       crater_x,
  input  logic [1:0][9:0]       crater_y,
  input  logic [1:0][5:0]       crater_r,
  input  logic [NROWS-1:0]      terrain_q,
  output logic [1:0]            ack,
  output logic [9:0]            read_addr,
  output logic [9:0]            write_addr,
  output logic [NROWS-1:0]      terrain_wdata,
  output logic                  we,
  output logic                  busy
);
  crater_state_e     state_q, state_d;
  crater_req_t       op_q, op_d;
  logic              grant_q, grant_d;
  logic [9:0]        col_q, col_d, last_q, last_d;
  logic [1:0]        rej_ack_q, rej_ack_d;
  logic [NROWS-1:0]  wdata_q, wdata_d, mask;
  logic              pick, take, chord_start, chord_done;
  logic [5:0]        h, chord_r;
  logic signed [10:0] dx, y_lo_s;
  logic [10:0]       x_hi, y_hi, lo, hi;
  logic [9:0]        cand_x, cand_y, first_col, last_col;
  logic [5:0]        cand_r;

`ifdef TERRAIN_RR_ARB_EN
  logic rr_q, rr_d;
  assign pick = req[rr_q] ? rr_q : ~rr_q;
  always_comb rr_d = take ? ~pick : rr_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`else
  assign pick = req[0] ? 1'b0 : 1'b1;
`endif

  // A rejected request's ack cycle also blocks a new grant
  assign take   = (state_q == ST_IDLE) && init_done && (req != '0) && (rej_ack_q == '0);
  assign cand_x = crater_x[pick];
  assign cand_y = crater_y[pick];
  assign cand_r = crater_r[pick];

  always_comb begin
    x_hi      = {1'b0, cand_x} + 11'(cand_r);
    first_col = (cand_x < 10'(cand_r)) ? '0 : cand_x - 10'(cand_r);
    last_col  = (x_hi > 11'(NCOLS - 1)) ? 10'(NCOLS - 1) : x_hi[9:0];
    dx        = $signed({1'b0, col_q}) - $signed({1'b0, op_q.x});
    y_lo_s    = $signed({1'b0, op_q.y}) - $signed({5'b0, h});
    lo        = y_lo_s[10] ? '0 : 11'(y_lo_s);
    y_hi      = {1'b0, op_q.y} + {5'b0, h};
    hi        = (y_hi > 11'(NROWS - 1)) ? 11'(NROWS - 1) : y_hi;
    for (int unsigned i = 0; i < NROWS; i++)
      mask[i] = (11'(i) >= lo) && (11'(i) <= hi);
  end

  assign chord_r = (state_q == ST_IDLE) ? cand_r : op_q.r;

  terrain_chord u_chord (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (chord_start),
    .r_i     (chord_r),
    .dx_i    (dx),
    .h_o     (h),
    .done_o  (chord_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    grant_d     = grant_q;
    col_d       = col_q;
    last_d      = last_q;
    rej_ack_d   = '0;
    wdata_d     = wdata_q;
    chord_start = 1'b0;
    case (state_q)
      ST_IDLE: if (take) begin
        grant_d = pick;
        op_d    = '{x: cand_x, y: cand_y, r: cand_r};
        if (cand_x >= 10'(NCOLS)) begin
          rej_ack_d[pick] = 1'b1;
        end else begin
          col_d       = first_col;
          last_d      = last_col;
          chord_start = 1'b1;
          state_d     = ST_CHORD;
        end
      end
      ST_CHORD: if (chord_done) state_d = vblank ? ST_READ : ST_PAUSE;
      ST_PAUSE: if (vblank) state_d = ST_READ;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        wdata_d = terrain_q & ~mask;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (col_q == last_q) begin
          state_d = ST_IDLE;
        end else begin
          col_d       = col_q + 10'd1;
          chord_start = 1'b1;
          state_d     = ST_CHORD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      grant_q   <= 1'b0;
      col_q     <= '0;
      last_q    <= '0;
      rej_ack_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      grant_q   <= grant_d;
      col_q     <= col_d;
      last_q    <= last_d;
      rej_ack_q <= rej_ack_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    ack = rej_ack_q;
    if ((state_q == ST_WRITE) && (col_q == last_q))
      ack = ack | (grant_q ? 2'b10 : 2'b01);
  end

  assign we            = (state_q == ST_WRITE);
  assign write_addr    = col_q;
  assign terrain_wdata = wdata_q;
  assign read_addr     = ((state_q == ST_READ) || (state_q == ST_WAIT)) ? col_q : display_x;
  assign busy          = (state_q != ST_IDLE) || (rej_ack_q != '0);
endmodule
